// File: rtl/lru_replace_if.sv
// Access/replace handshake between the update stage and the LRU unit.
// master: update stage (index, access, replace); slave: LRU unit (victim, status).
interface lru_replace_if #(
  parameter int idx_w = 9
);
  logic [idx_w-1:0] index;
  logic             access_valid;
  logic [4:0]       access_way;
  logic             replace;
  logic [4:0]       replace_way;
  logic             block_replace;
  logic             busy;
  logic             dropped_access;
  logic [15:0]      evict_count;

  modport master (
    output index, access_valid, access_way, replace,
    input  replace_way, block_replace, busy,
    input  dropped_access, evict_count
  );

  modport slave (
    input  index, access_valid, access_way, replace,
    output replace_way, block_replace, busy,
    output dropped_access, evict_count
  );
endinterface

// File: rtl/lru_replace_unit.sv
// True-LRU age tracking per set; scans a full set one way per cycle and
// grants the LRU victim. Ports: clk, rst (sync, high), bus (slave modport).
module lru_replace_unit #(
  parameter int way             = 4,
  parameter int block_size_byte = 16,
  parameter int cache_size_byte = 32768
) (
  input logic        clk,
  input logic        rst,
  lru_replace_if.slave bus
);
  localparam int set       = cache_size_byte / (block_size_byte * way);
  localparam int set_index = $clog2(set);
  localparam int age_w     = $clog2(way);

  typedef enum logic [1:0] {
    S_IDLE, S_SCAN, S_GRANT, S_WAIT
  } state_t;

  state_t               state;
  logic [age_w-1:0]     age [set][way];
  logic [set_index-1:0] idx_q;
  logic [age_w-1:0]     scan_ptr;
  logic [age_w-1:0]     best_way;
  logic [age_w-1:0]     next_best;
  logic [4:0]           rway_q;
  logic                 block_q;
  logic                 busy_q;
  logic                 drop_q;
  logic [15:0]          evict_q;

  logic                 acc_ok;
  logic                 t_en;
  logic [set_index-1:0] t_set;
  logic [age_w-1:0]     t_way;
  logic [age_w-1:0]     t_age;
  logic [age_w-1:0]     a_ptr;
  logic [age_w-1:0]     a_best;

  assign acc_ok = bus.access_valid &&
                  (bus.access_way < 5'(way));

  // One touch per cycle: the victim touch in GRANT never
  // collides with an access, since accesses are dropped there.
  always_comb begin
    t_en  = 1'b0;
    t_set = bus.index;
    t_way = bus.access_way[age_w-1:0];
    unique case (1'b1)
      (state == S_GRANT): begin
        t_en  = 1'b1;
        t_set = idx_q;
        t_way = rway_q[age_w-1:0];
      end
      (state == S_IDLE),
      (state == S_WAIT): t_en = acc_ok;
      default: t_en = 1'b0;
    endcase
  end

  assign t_age  = age[t_set][t_way];
  assign a_ptr  = age[idx_q][scan_ptr];
  assign a_best = age[idx_q][best_way];
  // Strict compare: ties keep the lower way.
  assign next_best = (a_ptr > a_best) ? scan_ptr : best_way;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < set; s++)
        for (int w = 0; w < way; w++)
          age[s][w] <= age_w'(w);
      state    <= S_IDLE;
      idx_q    <= '0;
      scan_ptr <= '0;
      best_way <= '0;
      rway_q   <= '0;
      block_q  <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      evict_q  <= '0;
    end else begin
      if (t_en) begin
        for (int j = 0; j < way; j++) begin
          if (age_w'(j) == t_way)
            age[t_set][j] <= '0;
          else if (age[t_set][j] < t_age)
            age[t_set][j] <= age[t_set][j] + 1'b1;
        end
      end
      block_q <= 1'b0;
      drop_q  <= acc_ok &&
                 (state == S_SCAN || state == S_GRANT);
      unique case (state)
        S_IDLE: begin
          if (bus.replace) begin
            idx_q    <= bus.index;
            scan_ptr <= '0;
            best_way <= '0;
            busy_q   <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          best_way <= next_best;
          scan_ptr <= scan_ptr + 1'b1;
          if (scan_ptr == age_w'(way - 1)) begin
            rway_q  <= 5'(next_best);
            block_q <= 1'b1;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          evict_q <= evict_q + 16'd1;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.replace) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.replace_way    = rway_q;
  assign bus.block_replace  = block_q;
  assign bus.busy           = busy_q;
  assign bus.dropped_access = drop_q;
  assign bus.evict_count    = evict_q;
endmodule

// File: tb/tb_lru_replace_unit.sv
// Bench for lru_replace_unit: table of replace scenarios plus
// hand sequences (dropped access, mid-scan reset, long replace).
module tb_lru_replace_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lru_replace_if #(.idx_w(9)) bus ();

  lru_replace_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [8:0] set;
    int         n_acc;
    logic [4:0] acc [4];
    logic [4:0] victim;
    int         post [4];
  } vec_t;

  typedef struct {
    logic [4:0] victim;
    int         due;
  } sb_t;

  vec_t vq [$];
  sb_t  sb [$];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   drops = 0;
  int   exp_evict = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match a pending request.
  always @(negedge clk) begin
    if (bus.dropped_access) drops++;
    if (!rst && bus.block_replace) begin
      sb_t e;
      strobes++;
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL strobe: got unexpected way %0d expected none",
                 bus.replace_way);
      end else begin
        e = sb.pop_front();
        chk("victim", int'(bus.replace_way), int'(e.victim));
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic add(logic [8:0] s, int n,
                     int a0, int a1, int a2, int a3, int v,
                     int p0, int p1, int p2, int p3);
    vec_t t;
    t.set = s;
    t.n_acc = n;
    t.acc[0] = 5'(a0);
    t.acc[1] = 5'(a1);
    t.acc[2] = 5'(a2);
    t.acc[3] = 5'(a3);
    t.victim = 5'(v);
    t.post[0] = p0;
    t.post[1] = p1;
    t.post[2] = p2;
    t.post[3] = p3;
    vq.push_back(t);
  endtask

  task automatic chk_ages(logic [8:0] s,
                          int p0, int p1, int p2, int p3);
    int e [4];
    e[0] = p0;
    e[1] = p1;
    e[2] = p2;
    e[3] = p3;
    for (int w = 0; w < 4; w++)
      chk($sformatf("age[%0d][%0d]", s, w),
          int'(dut.age[s][w]), e[w]);
  endtask

  task automatic do_access(logic [8:0] s, logic [4:0] w);
    bus.index = s;
    bus.access_way = w;
    bus.access_valid = 1'b1;
    @(posedge clk);
    #1 bus.access_valid = 1'b0;
  endtask

  // Waits for the strobe, drops replace a cycle later,
  // then waits for the unit to go idle.
  task automatic finish_grant();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.block_replace) got = 1;
    end
    if (!got) chk("grant_timeout", 0, 1);
    @(posedge clk);
    #1 bus.replace = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!bus.busy) got = 1;
    end
    if (!got) chk("idle_timeout", 0, 1);
  endtask

  task automatic start_replace(logic [8:0] s, logic [4:0] v);
    bus.index = s;
    bus.replace = 1'b1;
    sb.push_back('{v, cyc + 1 + 4});
    exp_evict++;
  endtask

  int s0;
  int d0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.index = '0;
    bus.access_valid = 1'b0;
    bus.access_way = '0;
    bus.replace = 1'b0;

    add(9'd5,   0, 0, 0, 0, 0, 3, 1, 2, 3, 0);
    add(9'd7,   4, 0, 1, 2, 3, 0, 0, 3, 2, 1);
    add(9'd2,   2, 3, 1, 0, 0, 2, 3, 1, 0, 2);
    add(9'd2,   0, 0, 0, 0, 0, 0, 0, 2, 1, 3);
    add(9'd11,  1, 2, 0, 0, 0, 3, 2, 3, 1, 0);
    add(9'd11,  2, 0, 3, 0, 0, 1, 2, 0, 3, 1);
    add(9'd0,   2, 1, 1, 0, 0, 3, 2, 1, 3, 0);
    add(9'd511, 2, 0, 2, 0, 0, 3, 2, 3, 1, 0);
    add(9'd4,   1, 7, 0, 0, 0, 3, 1, 2, 3, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_block", int'(bus.block_replace), 0);
    chk("rst_way", int'(bus.replace_way), 0);
    chk("rst_evict", int'(bus.evict_count), 0);
    chk("rst_drop", int'(bus.dropped_access), 0);
    chk_ages(9'd0, 0, 1, 2, 3);
    chk_ages(9'd511, 0, 1, 2, 3);
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      for (int a = 0; a < vq[i].n_acc; a++)
        do_access(vq[i].set, vq[i].acc[a]);
      start_replace(vq[i].set, vq[i].victim);
      @(posedge clk);
      #1 bus.index = ~vq[i].set;
      finish_grant();
      chk_ages(vq[i].set, vq[i].post[0], vq[i].post[1],
               vq[i].post[2], vq[i].post[3]);
      chk("evict_count", int'(bus.evict_count), exp_evict);
      @(posedge clk);
      #1;
    end

    // Access during SCAN is dropped with one pulse.
    d0 = drops;
    start_replace(9'd9, 5'd3);
    @(posedge clk);
    #1;
    bus.index = 9'd9;
    bus.access_way = 5'd1;
    bus.access_valid = 1'b1;
    @(posedge clk);
    #1 bus.access_valid = 1'b0;
    finish_grant();
    chk("drop_pulses", drops - d0, 1);
    chk_ages(9'd9, 1, 2, 3, 0);
    @(posedge clk);
    #1;

    // Reset sampled at E0+3 aborts the request silently.
    s0 = strobes;
    bus.index = 9'd3;
    bus.replace = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.replace = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_evict = 0;
    repeat (8) @(negedge clk);
    chk("abort_strobes", strobes - s0, 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_evict", int'(bus.evict_count), 0);
    chk_ages(9'd5, 0, 1, 2, 3);
    chk_ages(9'd7, 0, 1, 2, 3);
    chk_ages(9'd2, 0, 1, 2, 3);
    @(posedge clk);
    #1;

    // Replace held for 10 cycles gives exactly one grant.
    s0 = strobes;
    start_replace(9'd20, 5'd3);
    repeat (10) @(posedge clk);
    #1 bus.replace = 1'b0;
    @(negedge clk);
    chk("hold_busy_wait", int'(bus.busy), 1);
    @(negedge clk);
    chk("hold_busy_idle", int'(bus.busy), 0);
    chk("hold_strobes", strobes - s0, 1);
    chk("hold_evict", int'(bus.evict_count), exp_evict);
    chk_ages(9'd20, 1, 2, 3, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end
endmodule

// File: doc/lru_replace_unit.md
Name: lru_replace_unit

Overview:
- Replacement-policy stage for the set-associative L1 data array; sits directly beside the find/update stage.
- Tracks true-LRU age per way per set from hit and fill notifications.
- When the update stage reports a full set (replace high), scans the set's ages, selects the LRU victim, and returns replace_way with a one-cycle block_replace strobe.

Parameters:
- way, 4, associativity (power of 2, 2..16)
- block_size_byte, 16, line size in bytes
- cache_size_byte, 32768, total capacity in bytes
- set, cache_size_byte/(block_size_byte*way), number of sets (derived, 512 at defaults)
- set_index, log2(set), index width (derived, 9 at defaults)
- age_w, log2(way), age counter width (derived, 2 at defaults)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous reset, active-high
- index  in  set_index  set of the current access/replacement
- access_valid  in  1  one-cycle pulse: access_way of set index was hit or filled
- access_way  in  5  way touched (becomes MRU)
- replace  in  1  level request from update stage; held high until the line is written
- replace_way  out  5  chosen victim; valid while block_replace=1, held afterwards
- block_replace  out  1  one-cycle strobe: write the line into replace_way
- busy  out  1  high in SCAN, GRANT and WAIT
- dropped_access  out  1  one-cycle pulse: access_valid ignored because busy in SCAN/GRANT
- evict_count  out  16  number of victims granted; wraps 0xFFFF->0

Behaviour:
- Storage: age[set][way], age_w bits each. 0 = MRU, way-1 = LRU. In every set the ages are always a permutation of 0..way-1.
- Reset (rst high at posedge), in one cycle:
  - age[s][w] <= w for all s, w
  - state <= IDLE
  - replace_way, block_replace, busy, dropped_access, evict_count <= 0
  - Reset mid-scan or mid-grant aborts silently; no strobe is issued.
- Touch(set s, way k):
  - Every way j with age[s][j] < age[s][k] increments.
  - age[s][k] <= 0.
  - Other ways are unchanged.
- access_valid handling:
  - In IDLE or WAIT: touch(index, access_way).
  - In SCAN or GRANT: ignored, and dropped_access pulses.
  - access_way >= way: ignored in every state, no pulse.
- FSM:
  - IDLE: on replace=1, latch index into idx_q, clear scan_ptr and best_way, go to SCAN. busy rises at this edge.
  - SCAN: one way per cycle. If age[idx_q][scan_ptr] > age[idx_q][best_way], then best_way <= scan_ptr. Ties keep the lower way number. scan_ptr increments. The edge that processes scan_ptr = way-1 sets replace_way <= final best, block_replace <= 1, and goes to GRANT.
  - GRANT: block_replace <= 0, touch(idx_q, replace_way), evict_count += 1, go to WAIT.
  - WAIT: stays until replace is sampled 0, then goes to IDLE. This prevents a second grant for the same request, since the update stage drops replace one cycle after writing.
- Latency: if replace is first sampled high at edge E0, block_replace is high for exactly the cycle after edge E0+way (4 edges later at defaults). It is never high for more than one cycle.
- If replace falls during SCAN: the scan completes and the grant still issues; the FSM then passes straight through WAIT.
- index changes after E0 have no effect on the ongoing request (idx_q is used).
- Victim guarantee: with a consistent permutation, the victim is the way whose age is way-1.

Test Plan:
- Reset, then replace on set 5 with no accesses -> block_replace high once, 4 cycles after E0, replace_way=3; afterwards set 5 ages = {1,2,3,0}, evict_count=1.
- Set 7: access ways 0,1,2,3 in order, then replace -> replace_way=0; set 7 ages after grant = {0,3,2,1}.
- Set 2: access way 3, then way 1, then replace -> replace_way=2; a second replace on set 2 (after the first drops) -> replace_way=0.
- access_valid during SCAN on set 9 -> dropped_access pulses once; set 9 ages unchanged except the victim touch.
- rst asserted the cycle after E0+2 -> block_replace never rises, busy=0, evict_count=0, all ages back to w.
- Hold replace high for 10 cycles -> exactly one block_replace pulse; FSM returns to IDLE one cycle after replace drops.
